lsu_rmw: RTL

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane.sv | 49 ++++
 rtl/lsu_rmw.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store read-modify-write unit.
package lsu_pkg;

  localparam logic [31:0]  BASE_ADDR_DEF = 32'h6800_0000;
  localparam int unsigned  WORDS_DEF     = 256;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Unsupported funct3 codes are folded into the misaligned path.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B, SZ_BU: mis = 1'b0;
      SZ_H, SZ_HU: mis = off[0];
      SZ_W:        mis = (off != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane extraction/extension for loads and byte/halfword merge for stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wd_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(word_i >> {off_i, 3'b000});
    lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];

    ld_o = '0;
    case (size_i)
      SZ_B:    ld_o = {{24{lane_b[7]}}, lane_b};
      SZ_BU:   ld_o = {24'h0, lane_b};
      SZ_H:    ld_o = {{16{lane_h[15]}}, lane_h};
      SZ_HU:   ld_o = {16'h0, lane_h};
      SZ_W:    ld_o = word_i;
      default: ld_o = '0;
    endcase

    st_o = word_i;
    case (size_i)
      SZ_B, SZ_BU: begin
        case (off_i)
          2'd0: st_o[7:0]   = wd_i[7:0];
          2'd1: st_o[15:8]  = wd_i[7:0];
          2'd2: st_o[23:16] = wd_i[7:0];
          2'd3: st_o[31:24] = wd_i[7:0];
          default: st_o = word_i;
        endcase
      end
      SZ_H, SZ_HU: begin
        if (off_i[1]) st_o[31:16] = wd_i[15:0];
        else          st_o[15:0]  = wd_i[15:0];
      end
      default: st_o = wd_i;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores into a word RAM.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned WORDS     = WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wd,
  output logic [31:0] core_rd,
  output logic        core_stall,
  output logic        core_misalign,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * WORDS) - 32'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic        mis_q, mis_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rd_q, rd_d;

  logic        in_window;
  logic [31:0] rd_word;
  logic [31:0] lane_word;
  logic [31:0] lane_ld;
  logic [31:0] lane_st;

  assign mem_a     = {addr_q[31:2], 2'b00};
  assign in_window = (mem_a >= BASE_ADDR) && (mem_a <= LAST_ADDR);
  assign rd_word   = in_window ? mem_rd : '0;
  // Loads extract straight from the live read word; merges use the word captured in RD.
  assign lane_word = (state_q == RD) ? rd_word : word_q;

  lsu_lane u_lane (
    .word_i (lane_word),
    .off_i  (addr_q[1:0]),
    .size_i (size_q),
    .wd_i   (wd_q),
    .ld_o   (lane_ld),
    .st_o   (lane_st)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wd_d    = wd_q;
    mis_d   = mis_q;
    word_d  = word_q;
    rd_d    = rd_q;

    case (state_q)
      IDLE: begin
        if (core_req) begin
          addr_d = core_addr;
          size_d = core_size;
          we_d   = core_we;
          wd_d   = core_wd;
          mis_d  = is_misaligned(core_size, core_addr[1:0]);
          if (mis_d) begin
            rd_d    = '0;
            state_d = DONE;
          end else if (core_we && (core_size == SZ_W)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        word_d = rd_word;
        if (we_q) begin
          state_d = WR;
        end else begin
          rd_d    = lane_ld;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      mis_q   <= 1'b0;
      word_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      mis_q   <= mis_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs are gated by RST so an access aborted mid-write never strobes the RAM.
  assign core_stall    = !RST && ((state_q == RD) || (state_q == WR) ||
                                  ((state_q == IDLE) && core_req));
  assign mem_we        = !RST && (state_q == WR);
  assign core_misalign = !RST && (state_q == DONE) && mis_q;
  assign core_rd       = RST ? '0 : rd_q;
  assign mem_wd        = lane_st;

endmodule
